// File: rtl/stamp_board_pkg.sv
// Shared types, field positions and start codes for the stamp board.
// Imported by the window, its hazard checker and the bus interface.
package stamp_pkg;

  localparam int DEPTH  = 8;
  localparam int WORD_W = 88;

  localparam int OP_LSB    = 82;
  localparam int OP_W      = 6;
  localparam int SRC1_LSB  = 77;
  localparam int SRC2_LSB  = 72;
  localparam int DEST_LSB  = 67;
  localparam int REG_W     = 5;
  localparam int IMM_LSB   = 35;
  localparam int IMM_W     = 32;
  localparam int TAKE_LSB  = 30;
  localparam int TAKE_W    = 5;
  localparam int STAMP_LSB = 0;
  localparam int STAMP_W   = 3;

  localparam logic [2:0] START_NONE = 3'b000;
  localparam logic [2:0] START_EXEC = 3'b100;
  localparam logic [2:0] START_WB   = 3'b001;

  localparam int STAMP_EXEC_BIT = 2;
  localparam int STAMP_WB_BIT   = 0;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [STAMP_W-1:0] stamp_t;
  typedef logic [REG_W-1:0]   reg_t;

  function automatic reg_t f_src1(input word_t w);
    return w[SRC1_LSB +: REG_W];
  endfunction

  function automatic reg_t f_src2(input word_t w);
    return w[SRC2_LSB +: REG_W];
  endfunction

  function automatic reg_t f_dest(input word_t w);
    return w[DEST_LSB +: REG_W];
  endfunction

  function automatic stamp_t f_stamp(input word_t w);
    return w[STAMP_LSB +: STAMP_W];
  endfunction

  // Entry form of a word: take index and stamp start cleared.
  function automatic word_t f_clear(input word_t w);
    word_t r;
    r = w;
    r[TAKE_LSB +: TAKE_W]   = '0;
    r[STAMP_LSB +: STAMP_W] = '0;
    return r;
  endfunction

  // Younger word y depends on older word o through a nonzero register.
  function automatic logic f_dep(input word_t o, input word_t y);
    reg_t d;
    d = f_dest(o);
    return (d != '0) && ((d == f_src1(y)) || (d == f_src2(y)));
  endfunction

endpackage

// File: rtl/stamp_board_if.sv
// Decode, execution-unit and retire buses of the stamp board.
// slave is the board side, master the environment side.
interface stamp_board_if #(
  parameter int NUM_UNITS = 2
);
  import stamp_pkg::*;

  logic [WORD_W-1:0]                 instr_in;
  logic                              instr_valid;
  logic                              instr_ready;
  logic                              flush;
  logic [3*DEPTH-1:0]                reg_start_flat;
  logic [WORD_W*DEPTH-1:0]           reg_out_flat;
  logic [NUM_UNITS*3*DEPTH-1:0]      stamp_flat;
  logic [NUM_UNITS*DEPTH-1:0]        stamp_in;
  logic [NUM_UNITS*TAKE_W*DEPTH-1:0] take_flat;
  logic [NUM_UNITS*DEPTH-1:0]        take_in;
  logic                              retire_valid;
  logic [WORD_W-1:0]                 retire_word;
  logic [3:0]                        occupancy;

  modport slave (
    input  instr_in, instr_valid, flush,
    input  stamp_flat, stamp_in, take_flat, take_in,
    output instr_ready, reg_start_flat, reg_out_flat,
    output retire_valid, retire_word, occupancy
  );

  modport master (
    output instr_in, instr_valid, flush,
    output stamp_flat, stamp_in, take_flat, take_in,
    input  instr_ready, reg_start_flat, reg_out_flat,
    input  retire_valid, retire_word, occupancy
  );

endinterface

// File: rtl/stamp_hazard_check.sv
// Start-code generation for every slot of the window.
// Slot 7 is oldest; only older valid slots can block a younger one.
module stamp_hazard_check
  import stamp_pkg::*;
(
  input  word_t [DEPTH-1:0]      i_word,
  input  logic  [DEPTH-1:0]      i_valid,
  output logic  [DEPTH-1:0][2:0] o_start
);

  logic [DEPTH-1:0] w_hazard;
  logic [DEPTH-1:0] w_older_wb;
  logic [DEPTH-1:0] w_exec;
  logic [DEPTH-1:0] w_wb;

  always_comb begin
    w_hazard   = '0;
    w_older_wb = '1;
    w_exec     = '0;
    w_wb       = '0;
    o_start    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = i + 1; j < DEPTH; j++) begin
        if (i_valid[j] && !i_word[j][STAMP_WB_BIT]) begin
          w_older_wb[i] = 1'b0;
          if (f_dep(i_word[j], i_word[i]))
            w_hazard[i] = 1'b1;
        end
      end
      w_exec[i] = i_valid[i] && (f_stamp(i_word[i]) == '0) &&
                  !w_hazard[i];
      // Bit 1 is reserved and deliberately ignored here.
      w_wb[i] = i_valid[i] && i_word[i][STAMP_EXEC_BIT] &&
                !i_word[i][STAMP_WB_BIT] && w_older_wb[i];
      unique case (1'b1)
        w_exec[i]: o_start[i] = START_EXEC;
        w_wb[i]:   o_start[i] = START_WB;
        default:   o_start[i] = START_NONE;
      endcase
    end
  end

endmodule

// File: rtl/stamp_board.sv
// Eight-slot in-order window owning the stamp protocol.
// Merges unit stamp/take strobes, retires oldest-first from slot 7.
module stamp_board
  import stamp_pkg::*;
#(
  parameter int NUM_UNITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  stamp_board_if.slave  bus
);

  word_t [DEPTH-1:0]      r_word;
  logic  [3:0]            r_occ;
  logic                   r_ret_valid;
  word_t                  r_ret_word;

  word_t [DEPTH-1:0]      w_merged;
  word_t [DEPTH-1:0]      w_next;
  logic  [DEPTH-1:0]      w_valid;
  logic  [DEPTH-1:0][2:0] w_start;
  logic  [3:0]            w_occ_ret;
  logic  [3:0]            w_occ_next;
  logic                   w_retire;
  logic                   w_ready;
  logic                   w_enq;

  always_comb begin
    w_valid = '0;
    for (int k = 0; k < DEPTH; k++)
      w_valid[k] = (k + int'(r_occ)) >= DEPTH;
  end

  assign w_retire  = w_valid[DEPTH-1] &&
                     r_word[DEPTH-1][STAMP_EXEC_BIT] &&
                     r_word[DEPTH-1][STAMP_WB_BIT];
  assign w_ready   = (r_occ < 4'(DEPTH)) || w_retire;
  assign w_enq     = bus.instr_valid && w_ready;
  assign w_occ_ret = r_occ - {3'b000, w_retire};

  // Strobes address pre-shift slots; lowest unit wins the take field.
  always_comb begin
    w_merged = r_word;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (bus.stamp_in[u*DEPTH+i])
            w_merged[i][STAMP_LSB +: STAMP_W] |=
              bus.stamp_flat[(u*DEPTH+i)*STAMP_W +: STAMP_W];
        end
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
          if (bus.take_in[u*DEPTH+i])
            w_merged[i][TAKE_LSB +: TAKE_W] =
              bus.take_flat[(u*DEPTH+i)*TAKE_W +: TAKE_W];
        end
      end
    end
  end

  always_comb begin
    w_next = w_merged;
    if (w_retire) begin
      w_next[0] = '0;
      for (int k = 1; k < DEPTH; k++)
        w_next[k] = w_merged[k-1];
    end
    if (w_enq) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k + int'(w_occ_ret) == DEPTH - 1)
          w_next[k] = f_clear(bus.instr_in);
      end
    end
    w_occ_next = w_occ_ret + {3'b000, w_enq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word      <= '0;
      r_occ       <= '0;
      r_ret_valid <= 1'b0;
      r_ret_word  <= '0;
    end else if (bus.flush) begin
      r_word      <= '0;
      r_occ       <= '0;
      r_ret_valid <= 1'b0;
    end else begin
      r_word      <= w_next;
      r_occ       <= w_occ_next;
      r_ret_valid <= w_retire;
      if (w_retire)
        r_ret_word <= r_word[DEPTH-1];
    end
  end

  stamp_hazard_check u_hazard (
    .i_word  (r_word),
    .i_valid (w_valid),
    .o_start (w_start)
  );

  always_comb begin
    bus.reg_out_flat   = '0;
    bus.reg_start_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_valid[k])
        bus.reg_out_flat[k*WORD_W +: WORD_W] = r_word[k];
      bus.reg_start_flat[k*3 +: 3] = w_start[k];
    end
  end

  assign bus.instr_ready  = w_ready;
  assign bus.occupancy    = r_occ;
  assign bus.retire_valid = r_ret_valid;
  assign bus.retire_word  = r_ret_word;

endmodule

// File: tb/tb_stamp_board.sv
// Directed bench for stamp_board: enqueue, stamps, hazards, retire,
// take priority, flush and asynchronous reset.
module tb_stamp_board;
  import stamp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stamp_board_if #(.NUM_UNITS(2)) bus ();

  stamp_board #(.NUM_UNITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [703:0] obs,
                     input logic [703:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    bus.stamp_in   = '0;
    bus.stamp_flat = '0;
    bus.take_in    = '0;
    bus.take_flat  = '0;
  endtask

  task automatic strobe(input int u, input int s, input logic [2:0] st,
                        input logic tk_en, input logic [4:0] tk);
    bus.stamp_in[u*8+s]          = 1'b1;
    bus.stamp_flat[(u*8+s)*3 +: 3] = st;
    if (tk_en) begin
      bus.take_in[u*8+s]           = 1'b1;
      bus.take_flat[(u*8+s)*5 +: 5] = tk;
    end
  endtask

  task automatic enq(input word_t w);
    bus.instr_in    = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
  endtask

  function automatic word_t mk(input logic [5:0] op, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [4:0] d,
                               input logic [31:0] imm);
    word_t w;
    w = '0;
    w[OP_LSB +: OP_W]     = op;
    w[SRC1_LSB +: REG_W]  = s1;
    w[SRC2_LSB +: REG_W]  = s2;
    w[DEST_LSB +: REG_W]  = d;
    w[IMM_LSB +: IMM_W]   = imm;
    return w;
  endfunction

  function automatic word_t slot(input int k);
    return bus.reg_out_flat[k*88 +: 88];
  endfunction

  function automatic logic [2:0] st(input int k);
    return bus.reg_start_flat[k*3 +: 3];
  endfunction

  word_t m1, a, b, f[9];

  initial begin
    bus.instr_in    = '0;
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b0;
    clr_strobes();
    #1;
    chk("rst_occ",   bus.occupancy, 4'd0);
    chk("rst_rv",    bus.retire_valid, 1'b0);
    chk("rst_rw",    bus.retire_word, '0);
    chk("rst_ready", bus.instr_ready, 1'b1);
    chk("rst_out",   bus.reg_out_flat, '0);
    chk("rst_start", bus.reg_start_flat, '0);
    step();
    rst = 1'b0;
    step();

    // MOV enters with junk in take/stamp fields which must be cleared
    m1 = mk(6'b101010, 5'd3, 5'd0, 5'd4, 32'h1234);
    enq(m1 | (88'h1f << 30) | 88'h7);
    chk("mov_occ",   bus.occupancy, 4'd1);
    chk("mov_word",  slot(7), m1);
    chk("mov_start", st(7), 3'b100);

    strobe(0, 7, 3'b100, 1'b1, 5'd5);
    step();
    clr_strobes();
    chk("exe_word",  slot(7), m1 | (88'd5 << 30) | 88'd4);
    chk("exe_start", st(7), 3'b001);

    strobe(0, 7, 3'b001, 1'b0, 5'd0);
    step();
    clr_strobes();
    chk("wb_start", st(7), 3'b000);
    chk("wb_rv",    bus.retire_valid, 1'b0);
    step();
    chk("ret_rv",   bus.retire_valid, 1'b1);
    chk("ret_word", bus.retire_word, m1 | (88'd5 << 30) | 88'd5);
    chk("ret_occ",  bus.occupancy, 4'd0);
    step();
    chk("ret_pulse", bus.retire_valid, 1'b0);

    // RAW hazard on r4
    a = mk(6'd1, 5'd1, 5'd2, 5'd4, 32'd0);
    b = mk(6'd2, 5'd4, 5'd5, 5'd6, 32'd0);
    enq(a);
    enq(b);
    chk("haz_old",   st(7), 3'b100);
    chk("haz_young", st(6), 3'b000);
    strobe(0, 7, 3'b100, 1'b0, 5'd0);
    step();
    clr_strobes();
    chk("haz_wb",    st(7), 3'b001);
    chk("haz_hold",  st(6), 3'b000);
    strobe(0, 7, 3'b001, 1'b0, 5'd0);
    step();
    clr_strobes();
    chk("haz_free",  st(6), 3'b100);
    // flush beats the pending retire of slot 7
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_occ", bus.occupancy, 4'd0);
    chk("fl_rv",  bus.retire_valid, 1'b0);

    // r0 never creates a hazard
    a = mk(6'd1, 5'd1, 5'd2, 5'd0, 32'd0);
    b = mk(6'd2, 5'd0, 5'd0, 5'd6, 32'd0);
    enq(a);
    enq(b);
    chk("r0_young", st(6), 3'b100);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;

    // Fill, then retire and enqueue on the same edge
    for (int k = 0; k < 9; k++)
      f[k] = mk(6'd3, 5'd1, 5'd2, 5'd0, 32'(k + 100));
    for (int k = 0; k < 8; k++)
      enq(f[k]);
    chk("full_occ",   bus.occupancy, 4'd8);
    chk("full_ready", bus.instr_ready, 1'b0);
    chk("full_s0",    slot(0), f[7]);
    chk("full_s7",    slot(7), f[0]);
    strobe(1, 7, 3'b101, 1'b0, 5'd0);
    step();
    clr_strobes();
    chk("rdy_on_ret", bus.instr_ready, 1'b1);
    enq(f[8]);
    chk("swap_occ", bus.occupancy, 4'd8);
    chk("swap_s0",  slot(0), f[8]);
    chk("swap_s7",  slot(7), f[1]);
    chk("swap_rv",  bus.retire_valid, 1'b1);
    chk("swap_rw",  bus.retire_word, f[0] | 88'd5);

    // Two units hit slot 3 together; unit 0 owns the take field
    strobe(0, 3, 3'b100, 1'b1, 5'd9);
    strobe(1, 3, 3'b001, 1'b1, 5'd12);
    step();
    clr_strobes();
    chk("tk_word", slot(3), f[5] | (88'd9 << 30) | 88'd5);
    chk("tk_rv",   bus.retire_valid, 1'b0);

    // Flush with a valid offer at occupancy 5
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int k = 0; k < 5; k++)
      enq(f[k]);
    chk("f5_occ", bus.occupancy, 4'd5);
    bus.flush       = 1'b1;
    bus.instr_in    = f[8];
    bus.instr_valid = 1'b1;
    step();
    bus.flush       = 1'b0;
    bus.instr_valid = 1'b0;
    chk("f5_occ0", bus.occupancy, 4'd0);
    chk("f5_out",  bus.reg_out_flat, '0);

    // Strobes to an invalid slot are dropped
    strobe(0, 7, 3'b111, 1'b1, 5'd7);
    step();
    clr_strobes();
    enq(f[2]);
    chk("inv_word",  slot(7), f[2]);
    chk("inv_start", st(7), 3'b100);

    // Asynchronous reset mid-stream
    strobe(0, 7, 3'b101, 1'b0, 5'd0);
    bus.instr_in    = f[3];
    bus.instr_valid = 1'b1;
    step();
    clr_strobes();
    bus.instr_valid = 1'b0;
    chk("pre_occ", bus.occupancy, 4'd2);
    step();
    chk("pre_rv",  bus.retire_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_occ",   bus.occupancy, 4'd0);
    chk("ar_rv",    bus.retire_valid, 1'b0);
    chk("ar_rw",    bus.retire_word, '0);
    chk("ar_ready", bus.instr_ready, 1'b1);
    chk("ar_out",   bus.reg_out_flat, '0);
    chk("ar_start", bus.reg_start_flat, '0);
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stamp_board.md
Name: stamp_board

Overview:
- Eight-slot in-order instruction window that owns the stamp protocol.
- Holds instruction words and their 3-bit stamps, and drives reg_start_flat/reg_out_flat to the execution units (mov, alu, ...).
- Merges the stamp/take updates those units return, and retires completed instructions oldest-first.
- Sits between decode and all execution units.

Parameters:
- NUM_UNITS, 2: number of execution units returning stamp/take buses.
- DEPTH, 8: slot count; fixed at 8 because the flat bus widths depend on it.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_in  in  88  decoded word; [87:82] opcode, [81:77] src1, [76:72] src2, [71:67] dest, [66:35] imm
- instr_valid  in  1  decode offers instr_in
- instr_ready  out  1  board accepts this cycle
- flush  in  1  synchronous clear of all slots
- reg_start_flat  out  24  per-slot start code, slot k at [3k+2:3k]
- reg_out_flat  out  704  per-slot word, slot k at [88k+87:88k]; [34:30] take index, [2:0] stamp
- stamp_flat  in  NUM_UNITS*24  per-unit stamp values, unit u at [24u+23:24u]
- stamp_in  in  NUM_UNITS*8  per-unit per-slot stamp strobes
- take_flat  in  NUM_UNITS*40  per-unit 5-bit take indices, same slot layout
- take_in  in  NUM_UNITS*8  per-unit per-slot take strobes
- retire_valid  out  1  one-cycle pulse, an instruction retired
- retire_word  out  88  word of the retired instruction
- occupancy  out  4  valid slot count, 0..8

Behaviour:
- Slot 7 is oldest. Valid slots are contiguous from slot 7 down to slot 8-occupancy.
- Reset (async, rst=1): all slots invalid, occupancy=0, retire_valid=0, retire_word=0, instr_ready=1.
- reg_start_flat, reg_out_flat and instr_ready are combinational from registered state only; there is no input-to-output path.
- Invalid slots drive reg_out=0 and reg_start=000.
- Stamp bits: [2] executed, [0] written back, [1] reserved. Bit [1] is stored and ORed like the others but never gates a start code.
- Execute start, reg_start=100, for slot i when all of these hold:
  - the slot is valid and its stamp is 000;
  - for every valid older slot j>i with stamp[0]=0, dest_j differs from src1_i and from src2_i.
  - Register 0 never creates a hazard.
- Writeback start, reg_start=001, for slot i when it is valid, stamp[2]=1, stamp[0]=0, and every valid older slot has stamp[0]=1. This makes writeback in order.
- Otherwise reg_start=000.
- Stamp merge at each edge:
  - new stamp = old stamp OR (OR over units u with stamp_in[u][i]=1 of stamp_flat[u] slot i).
  - Bits are only ever set.
  - Strobes to invalid slots are ignored.
- Take merge: for slot i, the lowest-numbered unit u with take_in[u][i]=1 writes bits [34:30]. Other strobing units are ignored.
- Latency: updates seen at edge t appear on reg_out/reg_start in cycle t+1. Units pulse strobes for one cycle only.
- Retire:
  - Occurs at an edge when slot 7 is valid with registered stamp[2]=1 and stamp[0]=1.
  - Slot 7 is dropped and every slot k shifts to k+1.
  - retire_valid=1 and retire_word=old slot 7 word in the following cycle.
  - At most one retire per edge.
- Update ordering at an edge: strobes target pre-shift indices and are applied before the shift. A strobe landing on the retiring slot is discarded.
- Enqueue:
  - instr_ready = occupancy<8, or a retire happens this edge.
  - On valid&&ready the word enters slot 7-occ', where occ' is occupancy after retire.
  - On entry, bits [2:0] and [34:30] are forced to 0.
- Simultaneous retire+enqueue at occupancy 8: accepted; occupancy stays 8.
- Flush (synchronous): has priority over enqueue, retire and strobes. All slots are cleared, occupancy=0 and retire_valid=0 next cycle.
- An rst assertion mid-operation aborts everything immediately. There is no partial retire.

Decomposition:
- Shared package stamp_pkg holds:
  - DEPTH=8, WORD_W=88;
  - field positions: opcode [87:82], src1 [81:77], src2 [76:72], dest [71:67], imm [66:35], take [34:30], stamp [2:0];
  - START_EXEC=3'b100, START_WB=3'b001, STAMP_EXEC_BIT=2, STAMP_WB_BIT=0.
- Sub-module stamp_hazard_check: combinational. Takes all slot words and valids; produces the 8 start codes.

Test Plan:
- Reset, enqueue MOV (opcode 101010, src1=3, dest=4) -> slot 7 valid, occupancy=1, reg_start slot7=100 next cycle.
- Unit0 stamp_in[7]=1, stamp=100, take_in[7]=1, take=5 -> slot7 [34:30]=5 and reg_start=001. Then stamp 101 -> retire_valid pulse with that word, occupancy=0.
- Enqueue dest=4 then src1=4 -> younger slot stays 000 until older gets stamp[0]=1, then shows 100. With src1=0 it shows 100 immediately.
- Fill 8 slots -> instr_ready=0. Retire slot 7 with instr_valid=1 the same edge -> new word in slot 0, occupancy stays 8.
- Unit0 take=9, unit1 take=12 on the same slot and cycle -> take field=9. Stamps 100 and 001 -> stamp=101.
- flush with instr_valid=1 at occupancy 5 -> occupancy=0, nothing enqueued. rst mid-stream -> all outputs at reset values immediately.
